ntt_radix_pipe: RTL and testbench
=================================

# ntt_radix_pipe

Pipelined, parametrised successor to the combinational combined radix-2/4/8 NTT butterfly core.
- Accepts one 8-lane vector per cycle over a valid/ready handshake and applies modular arithmetic mod `Q` throughout.
- Executes four radix-2, two radix-4 or one radix-8 butterfly network with a fixed latency independent of mode.
- Sits between the coefficient memory read port and the write-back path of the NTT/INTT engine.

## Interface
Parameters:
- `WIDTH`, 18, lane width in bits
- `Q`, 12289, prime modulus; `Q < 2**WIDTH`
- `N_INV`, 1, scaling factor mod Q, used only under `NTT_RADIX_INV_SCALE_EN`

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: input vector valid
- `in_ready` out 1: input accepted when `in_valid && in_ready`
- `in_data` in 8*WIDTH: lanes x0..x7, x0 in the LSBs
- `in_psi` in 8*WIDTH: psi0..psi7
- `in_w` in 3*WIDTH: w1, w2, w3 (w1 in the LSBs)
- `in_mode` in 2: 00 = R2x4, 01 = R4x2, 10 = R8, 11 = same as 10
- `in_intt` in 1: 0 = NTT, 1 = INTT
- `out_valid` out 1: output vector valid
- `out_ready` in 1: downstream accepts
- `out_data` out 8*WIDTH: lanes y0..y7

## Operation
- Butterfly bf(a, b, w):
  - t = (b*w) mod Q, full 2*WIDTH product
  - hi = (a+t) mod Q
  - lo = (a−t+Q) mod Q
- Capture stage R0:
  - Reduce each lane mod Q.
  - NTT: multiply lane k by psi_k mod Q.
  - INTT: pass lanes unchanged.
  - Mode, intt flag, w and psi travel down the pipeline with the data.
- Stage R1: bf on (x0,x1), (x2,x3), (x4,x5), (x6,x7), all with w = 1. Results are s0..s7 in place (hi to the even index, lo to the odd index).
- Stage R2, active in modes 01 and 10: bf on (s0,s2,1), (s1,s3,w2), (s4,s6,1), (s5,s7,w2) gives t0..t7. In mode 00 the stage passes its input through.
- Stage R3, active in mode 10: bf on (t0,t4,1), (t1,t5,w1), (t2,t6,w2), (t3,t7,w3) gives u0..u7. In other modes the stage passes its input through.
- Stage R4:
  - INTT: y_k = (lane_k * psi_k) mod Q.
  - NTT: y_k = lane_k.
- Pass-through stages still register, so latency is constant across modes.
- Mid-stream mode or intt changes are legal per vector; no flush is required.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0.
  - All stage valids are 0.
  - `in_ready` = 1 once `rst_n` is high.
- Pipeline enable: en = `out_ready` || !`out_valid`.
  - All stages advance together when en = 1.
  - `in_ready` = en, driven combinationally.
- Latency: a vector accepted at edge k appears with `out_valid` = 1 after edge k+5, provided there is no stall.
- Throughput: 1 vector per cycle.
- Bubbles (`in_valid` = 0) propagate as invalid slots and do not compress.
- Stall (`out_ready` = 0 with `out_valid` = 1):
  - All registers hold.
  - `out_data` is stable.
  - `in_ready` = 0.
- An `out_ready` low while `out_valid` = 0 does not stall.
- Asserting `rst_n` low mid-operation clears every valid immediately. In-flight vectors are discarded and no partial output is emitted.

## Configuration
- `NTT_RADIX_INV_SCALE_EN` defined:
  - Adds stage R5. In INTT, y_k = (R4 lane * N_INV) mod Q; NTT passes through.
  - Latency becomes 6 cycles for both modes.
- Undefined:
  - No R5; latency is 5.
  - `N_INV` is ignored.

## Test plan
- R8, NTT, psi = 1, w = 1, x = [1,0,0,0,0,0,0,0] -> y = [1,1,1,1,1,1,1,1], 5 cycles after accept.
- R8, NTT, psi = 1, w = 1, x = all 1 -> y0 = 8, all other lanes 0. Then x0 = 12290 (≥ Q), all other lanes 0 -> all lanes 1.
- R2x4, NTT, psi = 1, x0 = 3, x1 = 5 -> y0 = 8, y1 = 12287.
- R4x2, INTT, psi = all 2, w2 = 1, x = all 1 -> y0 = 8, y4 = 8, others 0. With the macro and N_INV = 3 -> y0 = 24, y4 = 24 at latency 6.
- Streaming 20 back-to-back vectors with `out_ready` toggled 1,0,0,1,... -> all 20 outputs in order, no duplicates, `out_data` stable while stalled.
- Reset pulse 2 cycles after three accepts -> `out_valid` stays 0 and the first new vector emerges exactly 5 cycles after acceptance.

Source files
------------

// File: rtl/ntt_radix_pipe.sv
// ntt_radix_pipe: pipelined radix-2/4/8 NTT/INTT butterfly network mod Q, fixed latency across modes.
// Define NTT_RADIX_INV_SCALE_EN to add a final INTT scaling stage by N_INV (latency 6 instead of 5).
module ntt_radix_pipe #(
   parameter int WIDTH = 18,
   parameter int Q     = 12289,
   parameter int N_INV = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*WIDTH-1:0]   in_data,
   input  logic [8*WIDTH-1:0]   in_psi,
   input  logic [3*WIDTH-1:0]   in_w,
   input  logic [1:0]           in_mode,
   input  logic                 in_intt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*WIDTH-1:0]   out_data
);
`ifdef NTT_RADIX_INV_SCALE_EN
   localparam int NS = 7;
   localparam logic [WIDTH-1:0] NINV = WIDTH'(N_INV % Q);
`else
   localparam int NS = 6;
`endif
   localparam int NI = NS - 1;
   localparam logic [WIDTH-1:0]   QR  = WIDTH'(Q);
   localparam logic [WIDTH:0]     Q1  = (WIDTH+1)'(Q);
   localparam logic [2*WIDTH-1:0] QW  = (2*WIDTH)'(Q);
   localparam logic [WIDTH-1:0]   ONE = WIDTH'(1);

   function automatic logic [WIDTH-1:0] mulmod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] p;
      p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
      return WIDTH'(p % QW);
   endfunction

   function automatic logic [WIDTH-1:0] addmod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] t);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, t};
      return s >= Q1 ? WIDTH'(s - Q1) : WIDTH'(s);
   endfunction

   function automatic logic [WIDTH-1:0] submod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] t);
      return a >= t ? a - t : WIDTH'({1'b0, a} + Q1 - {1'b0, t});
   endfunction

   function automatic logic [2*WIDTH-1:0] bf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] w);
      logic [WIDTH-1:0] t;
      t = mulmod(b, w);
      return {addmod(a, t), submod(a, t)};
   endfunction

   // Side-band fields are only carried as deep as the last stage that consumes them.
   logic [NS-1:0]                   v;
   logic [NS-1:0][7:0][WIDTH-1:0]   d, nd;
   logic [4:0][7:0][WIDTH-1:0]      ps;
   logic [3:0][2:0][WIDTH-1:0]      wt;
   logic [3:0][1:0]                 md;
   logic [NI-1:0]                   it;
   logic [7:0][WIDTH-1:0]           b2, b3;
   logic [3:0][WIDTH-1:0]           w4;
   logic                            en;

   assign en        = out_ready || !v[NS-1];
   assign in_ready  = en;
   assign out_valid = v[NS-1];
   assign out_data  = d[NS-1];
   assign w4        = {wt[3], ONE};

   always_comb begin
      nd    = '0;
      b2    = d[2];
      b3    = d[3];
      nd[0] = in_data;
      for (int k = 0; k < 8; k++) begin
         nd[1][k] = it[0] ? d[0][k] % QR : mulmod(d[0][k] % QR, ps[0][k]);
         nd[5][k] = it[4] ? mulmod(d[4][k], ps[4][k]) : d[4][k];
`ifdef NTT_RADIX_INV_SCALE_EN
         nd[6][k] = it[5] ? mulmod(d[5][k], NINV) : d[5][k];
`endif
      end
      for (int j = 0; j < 4; j++) begin
         {nd[2][2*j], nd[2][2*j+1]} = bf(d[1][2*j], d[1][2*j+1], ONE);
         {b2[4*(j/2)+j%2], b2[4*(j/2)+j%2+2]} = bf(d[2][4*(j/2)+j%2], d[2][4*(j/2)+j%2+2], j % 2 == 1 ? wt[2][1] : ONE);
         {b3[j], b3[j+4]} = bf(d[3][j], d[3][j+4], w4[j]);
      end
      nd[3] = md[2] != 2'd0 ? b2 : d[2];
      nd[4] = md[3] >= 2'd2 ? b3 : d[3];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v  <= '0;
         d  <= '0;
         ps <= '0;
         wt <= '0;
         md <= '0;
         it <= '0;
      end else if (en) begin
         v  <= {v[NS-2:0], in_valid};
         d  <= nd;
         ps <= {ps[3:0], in_psi};
         wt <= {wt[2:0], in_w};
         md <= {md[2:0], in_mode};
         it <= {it[NI-2:0], in_intt};
      end
   end
endmodule

// File: tb/tb_ntt_radix_pipe.sv
// tb_ntt_radix_pipe: directed vectors with hand-computed results, latency, stall and reset checks.
module tb_ntt_radix_pipe;
   localparam int W  = 18;
   localparam int VW = 8*W;
`ifdef NTT_RADIX_INV_SCALE_EN
   localparam int LAT = 6;
   localparam int S   = 3;
`else
   localparam int LAT = 5;
   localparam int S   = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_ready, in_intt, out_valid, out_ready;
   logic [1:0]    in_mode;
   logic [VW-1:0] in_data, in_psi, out_data;
   logic [3*W-1:0] in_w;
   int            n_cmp = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   ntt_radix_pipe #(.WIDTH(W), .Q(12289), .N_INV(3)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_psi(in_psi), .in_w(in_w), .in_mode(in_mode),
      .in_intt(in_intt), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   function automatic logic [VW-1:0] v8(input int a0, a1, a2, a3, a4, a5, a6, a7);
      return {W'(a7), W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
   endfunction

   function automatic logic [3*W-1:0] w3(input int a, b, c);
      return {W'(c), W'(b), W'(a)};
   endfunction

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic run1(input string tag, input logic [VW-1:0] x, input logic [VW-1:0] p,
                       input logic [3*W-1:0] w, input logic [1:0] m, input logic iv,
                       input logic [VW-1:0] e);
      int n;
      in_data = x; in_psi = p; in_w = w; in_mode = m; in_intt = iv; in_valid = 1'b1;
      @(negedge clk);
      chk({tag, "_rdy"}, VW'(in_ready), VW'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!out_valid && n < 12);
      chk({tag, "_lat"}, VW'(n), VW'(LAT));
      chk({tag, "_dat"}, out_data, e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [VW-1:0] ones;
      int nh;
      ones = v8(1, 1, 1, 1, 1, 1, 1, 1);
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_intt = 1'b0; in_mode = 2'b00;
      in_data = '0; in_psi = '0; in_w = '0;
      #1;
      chk("rst_ov", VW'(out_valid), '0);
      chk("rst_od", out_data, '0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("rst_rdy", VW'(in_ready), VW'(1));
      @(posedge clk); #1;

      run1("r8_imp", v8(1, 0, 0, 0, 0, 0, 0, 0), ones, w3(1, 1, 1), 2'b10, 1'b0, ones);
      run1("r8_dc", ones, ones, w3(1, 1, 1), 2'b10, 1'b0, v8(8, 0, 0, 0, 0, 0, 0, 0));
      run1("r8_red", v8(12290, 0, 0, 0, 0, 0, 0, 0), ones, w3(1, 1, 1), 2'b11, 1'b0, ones);
      run1("r2_bf", v8(3, 5, 0, 0, 0, 0, 0, 0), ones, w3(1, 1, 1), 2'b00, 1'b0,
           v8(8, 12287, 0, 0, 0, 0, 0, 0));
      run1("r2_psi", v8(1, 1, 0, 0, 0, 0, 0, 0), v8(2, 3, 1, 1, 1, 1, 1, 1), w3(1, 1, 1), 2'b00, 1'b0,
           v8(5, 12288, 0, 0, 0, 0, 0, 0));
      run1("r4_intt", ones, v8(2, 2, 2, 2, 2, 2, 2, 2), w3(1, 1, 1), 2'b01, 1'b1,
           v8(8*S, 0, 0, 0, 8*S, 0, 0, 0));
      run1("r4_w2", v8(0, 0, 0, 1, 0, 0, 0, 0), ones, w3(1, 7, 1), 2'b01, 1'b0,
           v8(1, 12282, 12288, 7, 0, 0, 0, 0));
      run1("r8_tw", v8(0, 0, 0, 0, 1, 0, 0, 0), ones, w3(2, 3, 5), 2'b10, 1'b0,
           v8(1, 2, 3, 5, 12288, 12287, 12286, 12284));

      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("idle_rdy", VW'(in_ready), VW'(1));
      @(posedge clk); #1;

      in_psi = ones; in_w = w3(1, 1, 1); in_mode = 2'b00; in_intt = 1'b0;
      fork
         begin : prod
            logic acc;
            for (int i = 0; i < 20; i++) begin
               in_data = v8(i, 0, 0, 0, 0, 0, 0, 0);
               in_valid = 1'b1;
               acc = 1'b0;
               for (int g = 0; g < 50 && !acc; g++) begin
                  @(negedge clk);
                  acc = in_ready;
                  @(posedge clk); #1;
               end
            end
            in_valid = 1'b0;
         end
         begin : cons
            logic [VW-1:0] held;
            logic stl;
            int got;
            stl = 1'b0; got = 0; held = '0;
            for (int c = 0; c < 400 && got < 20; c++) begin
               out_ready = (c % 4 == 0) || (c % 4 == 3);
               @(negedge clk);
               if (stl) chk("stall_hold", out_data, held);
               stl = out_valid && !out_ready;
               held = out_data;
               if (stl) chk("stall_rdy", VW'(in_ready), '0);
               if (out_valid && out_ready) begin
                  chk("stream", out_data, v8(got, got, 0, 0, 0, 0, 0, 0));
                  got++;
               end
               @(posedge clk); #1;
            end
            chk("stream_cnt", VW'(got), VW'(20));
         end
      join
      out_ready = 1'b1;
      @(posedge clk); #1;

      in_psi = ones; in_mode = 2'b10; in_intt = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = v8(i + 1, 0, 0, 0, 0, 0, 0, 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1 chk("rst_async", VW'(out_valid), '0);
      @(negedge clk) rst_n = 1'b1;
      nh = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         nh += int'(out_valid);
      end
      chk("rst_flush", VW'(nh), '0);
      @(posedge clk); #1;
      run1("rst_new", v8(1, 0, 0, 0, 0, 0, 0, 0), ones, w3(1, 1, 1), 2'b10, 1'b0, ones);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
